la_bus_arbiter: RTL

LA_BUS_ARBITER -- requirements
Module: la_bus_arbiter

---
 rtl/la_arb_pkg.sv | 21 ++
 rtl/la_rr_pick.sv | 33 +++
 rtl/la_bus_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/la_arb_pkg.sv
// la_arb_pkg: shared types and constants for the la bus arbiter.
// State encoding is visible to software through status.state.
package la_arb_pkg;

  localparam int MAX_NUM_REQ = 8;
  localparam int IDX_W = $clog2(MAX_NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_OWN  = 2'd2,
    ST_LOCK = 2'd3
  } arb_state_e;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_OWNER = 1;
  localparam int STAT_STATE = 6;
  localparam int STAT_STATS = 8;
  localparam int STAT_W     = 16;

endpackage

// File: rtl/la_rr_pick.sv
// la_rr_pick: combinational round-robin picker.
// Nearest requester after i_last wins, wrapping at N.
module la_rr_pick
  import la_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  int w_best;
  int w_dist;

  // keep the requester with the smallest distance past i_last
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_best  = N;
    w_dist  = 0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i + 2 * N - int'(i_last) - 1) % N;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_valid = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/la_bus_arbiter.sv
// la_bus_arbiter: round-robin owner of the la expansion bus.
// Preemption counter in status.stats: define LA_BUS_ARBITER_STATS_EN.
module la_bus_arbiter
  import la_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int BUS_W      = 34,
  parameter int TURNAROUND = 2,
  parameter int MAX_HOLD   = 256
) (
  input  logic                     sys_clk,
  input  logic                     reset_n,
  input  logic                     host_lock,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*BUS_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [BUS_W-1:0]         bus_dout,
  output logic                     bus_oe,
  output logic [STAT_W-1:0]        status
);

  localparam logic [IDX_W-1:0] LAST_RST =
    IDX_W'(NUM_REQ - 1);
  localparam logic [3:0]  TURN_LAST = 4'(TURNAROUND - 1);
  localparam logic [15:0] HOLD_SAT  = 16'(MAX_HOLD);
  localparam logic [15:0] HOLD_LIM  = 16'(MAX_HOLD - 1);

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;

  arb_state_e         r_state;
  arb_state_e         w_state_nx;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   w_owner_nx;
  logic [3:0]         r_turn;
  logic [3:0]         w_turn_nx;
  logic [15:0]        r_hold;
  logic [15:0]        w_hold_nx;
  logic [BUS_W-1:0]   r_dout;

  logic [NUM_REQ-1:0] w_onehot;
  logic [BUS_W-1:0]   w_sel;
  logic               w_pick_vld;
  logic [IDX_W-1:0]   w_pick;
  logic               w_own_req;
  logic               w_others;
  logic               w_hold_hit;
  logic               w_preempt;
  logic               w_drive;
  logic [7:0]         w_stats;
  logic [STAT_W-1:0]  w_status;

  // two-flop release of reset; assertion stays asynchronous
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  la_rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .i_req   (req),
    .i_last  (r_owner),
    .o_valid (w_pick_vld),
    .o_idx   (w_pick)
  );

  // one-hot view of the owner and its data slice
  always_comb begin
    w_onehot = '0;
    w_sel    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == IDX_W'(i)) begin
        w_onehot[i] = 1'b1;
        w_sel       = req_data[i*BUS_W +: BUS_W];
      end
    end
  end

  assign w_own_req  = |(req & w_onehot);
  assign w_others   = |(req & ~w_onehot);
  assign w_hold_hit = (r_hold >= HOLD_LIM);

  // next state; host_lock overrides every state
  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_turn_nx  = r_turn;
    w_hold_nx  = r_hold;
    w_preempt  = 1'b0;
    if (host_lock) begin
      w_state_nx = ST_LOCK;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_LOCK: begin
          if (w_pick_vld) begin
            w_state_nx = ST_TURN;
            w_owner_nx = w_pick;
            w_turn_nx  = '0;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end
        ST_TURN: begin
          if (r_turn == TURN_LAST) begin
            if (w_own_req) begin
              w_state_nx = ST_OWN;
              w_hold_nx  = '0;
            end else begin
              w_state_nx = ST_IDLE;
            end
          end else begin
            w_turn_nx = r_turn + 4'd1;
          end
        end
        ST_OWN: begin
          if (r_hold != HOLD_SAT) begin
            w_hold_nx = r_hold + 16'd1;
          end
          if (!w_own_req) begin
            if (w_pick_vld) begin
              w_state_nx = ST_TURN;
              w_owner_nx = w_pick;
              w_turn_nx  = '0;
            end else begin
              w_state_nx = ST_IDLE;
            end
          end else if (w_hold_hit && w_others) begin
            w_state_nx = ST_TURN;
            w_owner_nx = w_pick;
            w_turn_nx  = '0;
            w_preempt  = 1'b1;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  // state registers, held at reset values until release is synced
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_owner <= LAST_RST;
      r_turn  <= '0;
      r_hold  <= '0;
    end else if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= LAST_RST;
      r_turn  <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_owner <= w_owner_nx;
      r_turn  <= w_turn_nx;
      r_hold  <= w_hold_nx;
    end
  end

  // registered drive data of the current owner
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout <= '0;
    end else if (!w_rst_n) begin
      r_dout <= '0;
    end else begin
      r_dout <= w_sel;
    end
  end

`ifdef LA_BUS_ARBITER_STATS_EN
  logic [7:0] r_stats;

  // wrapping count of hold-limit preemptions
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stats <= '0;
    end else if (!w_rst_n) begin
      r_stats <= '0;
    end else if (w_preempt) begin
      r_stats <= r_stats + 8'd1;
    end
  end

  assign w_stats = r_stats;
`else
  logic w_unused_preempt;
  assign w_unused_preempt = w_preempt;
  assign w_stats = '0;
`endif

  // host_lock kills the grant in the cycle it rises
  assign w_drive = w_rst_n && !host_lock &&
                   (r_state == ST_OWN);

  assign bus_oe   = w_drive;
  assign gnt      = w_drive ? w_onehot : '0;
  assign bus_dout = r_dout;

  // status word; all zero while reset is held
  always_comb begin
    w_status = '0;
    if (w_rst_n) begin
      w_status[STAT_BUSY] = (r_state == ST_TURN) ||
                            (r_state == ST_OWN);
      w_status[STAT_OWNER +: IDX_W] = r_owner;
      w_status[STAT_STATE +: 2]     = r_state;
      w_status[STAT_STATS +: 8]     = w_stats;
    end
  end

  assign status = w_status;

endmodule
